// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl
// Computes the low 32 bits of an unsigned 32x32 product using one shared,
// registered 16x16 multiplier. Three partial products are issued in order
// (a_lo*b_lo, a_lo*b_hi, a_hi*b_lo) and accumulated as
//    result = p1 + ((p2 + p3) << 16)  mod 2^32
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. The producer holds valid (and its data) until
// the transfer; ready never depends on valid.
//
// Ports:
//    clk         rising-edge clock
//    reset       asynchronous, active-high reset
//    req_valid   request operands valid
//    req_ready   block can accept a request (IDLE only, low during reset)
//    req_src1    multiplicand
//    req_src2    multiplier
//    mul_a       operand A to the shared multiplier
//    mul_b       operand B to the shared multiplier
//    mul_en      clock enable to the multiplier pipeline registers
//    mul_p       product from the multiplier, MUL_LATENCY cycles after a slot
//    rsp_valid   result valid (DONE)
//    rsp_ready   consumer accepts the result
//    rsp_result  low 32 bits of src1*src2
//    busy        high in any state other than IDLE
//    state_dbg   current FSM state encoding (IDLE=0, ISSUE=1, DRAIN=2, DONE=3)
//
// MUL_LATENCY: cycles from a mul_en-qualified slot to its product, 1..3.

module mul_seq_ctrl #(
   parameter int MUL_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_src1,
   input  logic [31:0] req_src2,
   output logic [15:0] mul_a,
   output logic [15:0] mul_b,
   output logic        mul_en,
   input  logic [31:0] mul_p,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic        busy,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state, state_next;

   logic [31:0] src1_q;
   logic [31:0] src2_q;
   logic [31:0] acc;
   logic [1:0]  issue_cnt;
   logic [1:0]  cap_cnt;

   // One bit per in-flight slot; the oldest bit marks the cycle where that
   // slot's product is present on mul_p.
   logic [MUL_LATENCY-1:0] vld_pipe;

   logic accept;
   logic issuing;
   logic cap;
   logic last_cap;

   assign accept   = (state == IDLE) && req_valid;
   assign issuing  = (state == ISSUE);
   assign cap      = vld_pipe[MUL_LATENCY-1];
   assign last_cap = cap && (cap_cnt == 2'd2);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req_valid)            state_next = ISSUE;
         ISSUE:   if (issue_cnt == 2'd2)    state_next = DRAIN;
         DRAIN:   if (last_cap)             state_next = DONE;
         DONE:    if (rsp_ready)            state_next = IDLE;
         default:                           state_next = IDLE;
      endcase
   end

   // Operand latch, issue counter, slot tracking and accumulation
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src1_q    <= 32'h0;
         src2_q    <= 32'h0;
         acc       <= 32'h0;
         issue_cnt <= 2'd0;
         cap_cnt   <= 2'd0;
         vld_pipe  <= '0;
      end else begin
         vld_pipe[0] <= issuing;
         for (int i = 1; i < MUL_LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
         end

         if (accept) begin
            src1_q    <= req_src1;
            src2_q    <= req_src2;
            acc       <= 32'h0;
            issue_cnt <= 2'd0;
            cap_cnt   <= 2'd0;
         end else begin
            if (issuing) begin
               issue_cnt <= (issue_cnt == 2'd2) ? 2'd0 : issue_cnt + 2'd1;
            end
            // Captures run on their own counter so they can overlap ISSUE
            // when the multiplier is shorter than three stages.
            if (cap) begin
               if (cap_cnt == 2'd0) begin
                  acc <= mul_p;
               end else begin
                  acc <= acc + {mul_p[15:0], 16'h0};
               end
               cap_cnt <= (cap_cnt == 2'd2) ? 2'd0 : cap_cnt + 2'd1;
            end
         end
      end
   end

   // Outputs
   always_comb begin
      mul_a      = 16'h0;
      mul_b      = 16'h0;
      mul_en     = 1'b0;
      rsp_valid  = 1'b0;
      rsp_result = 32'h0;
      case (state)
         ISSUE: begin
            mul_en = 1'b1;
            case (issue_cnt)
               2'd0: begin
                  mul_a = src1_q[15:0];
                  mul_b = src2_q[15:0];
               end
               2'd1: begin
                  mul_a = src1_q[15:0];
                  mul_b = src2_q[31:16];
               end
               default: begin
                  mul_a = src1_q[31:16];
                  mul_b = src2_q[15:0];
               end
            endcase
         end
         // Keep the multiplier pipeline advancing until product 3 lands.
         DRAIN: mul_en = 1'b1;
         DONE: begin
            rsp_valid  = 1'b1;
            rsp_result = acc;
         end
         default: ;
      endcase
   end

   // Gated by reset so the block never advertises ready while held in reset.
   assign req_ready = (state == IDLE) && !reset;
   assign busy      = (state != IDLE);
   assign state_dbg = state;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Testbench for mul_seq_ctrl. Instance 0 uses MUL_LATENCY=1, instance 1 uses
// MUL_LATENCY=3; each drives its own behavioural registered multiplier.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_mul_seq_ctrl;

   logic        clk;
   logic [1:0]  reset;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [1:0]  mul_en;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [1:0]  busy;
   logic [31:0] src1 [2];
   logic [31:0] src2 [2];
   logic [31:0] mul_p [2];
   logic [31:0] rsp_result [2];
   logic [15:0] mul_a [2];
   logic [15:0] mul_b [2];
   logic [1:0]  state_dbg [2];

   int n_checks;
   int n_fail;

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   mul_seq_ctrl #(.MUL_LATENCY(1)) dut0 (
      .clk(clk), .reset(reset[0]),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_src1(src1[0]), .req_src2(src2[0]),
      .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_en(mul_en[0]), .mul_p(mul_p[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]),
      .busy(busy[0]), .state_dbg(state_dbg[0])
   );

   mul_seq_ctrl #(.MUL_LATENCY(3)) dut1 (
      .clk(clk), .reset(reset[1]),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_src1(src1[1]), .req_src2(src2[1]),
      .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_en(mul_en[1]), .mul_p(mul_p[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]),
      .busy(busy[1]), .state_dbg(state_dbg[1])
   );

   // ---------------- multiplier models ----------------
   logic [31:0] m0_s0;
   logic [31:0] m1_s0, m1_s1, m1_s2;

   always @(posedge clk) begin
      if (mul_en[0]) m0_s0 <= 32'(mul_a[0]) * 32'(mul_b[0]);
      if (mul_en[1]) begin
         m1_s0 <= 32'(mul_a[1]) * 32'(mul_b[1]);
         m1_s1 <= m1_s0;
         m1_s2 <= m1_s1;
      end
   end
   assign mul_p[0] = m0_s0;
   assign mul_p[1] = m1_s2;

   // ---------------- tests ----------------
   task automatic test_reset();
      reset     = 2'b11;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      for (int s = 0; s < 2; s++) begin
         src1[s] = 32'h0;
         src2[s] = 32'h0;
      end
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         n_checks++;
         if (req_ready[s] !== 1'b0 || rsp_valid[s] !== 1'b0 || mul_en[s] !== 1'b0 ||
             busy[s] !== 1'b0 || rsp_result[s] !== 32'h0 || mul_a[s] !== 16'h0 ||
             mul_b[s] !== 16'h0 || state_dbg[s] !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_values inst%0d: rdy=%b vld=%b en=%b busy=%b res=%h a=%h b=%h st=%0d, required all zero",
                     s, req_ready[s], rsp_valid[s], mul_en[s], busy[s], rsp_result[s], mul_a[s], mul_b[s], state_dbg[s]);
         end
      end
      reset = 2'b00;
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         n_checks++;
         if (req_ready[s] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready inst%0d: req_ready=%b required 1", s, req_ready[s]);
         end
      end
   endtask

   // Runs one operation with rsp_ready=1 and checks slot operands, latency,
   // result, one-cycle rsp_valid and req_ready afterwards.
   task automatic do_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string nm);
      int w;
      int lat;
      int exp_lat;
      logic [15:0] ea, eb;
      exp_lat = (sel == 0) ? 5 : 7;
      @(negedge clk);
      req_valid[sel] = 1'b1;
      src1[sel]      = a;
      src2[sel]      = b;
      rsp_ready[sel] = 1'b1;
      w = 0;
      while (req_ready[sel] !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      n_checks++;
      if (req_ready[sel] !== 1'b1) begin
         n_fail++;
         $display("FAIL %s accept_timeout: req_ready=%b required 1", nm, req_ready[sel]);
         req_valid[sel] = 1'b0;
         return;
      end
      @(posedge clk);
      lat = 0;
      for (int c = 1; c <= 12 && lat == 0; c++) begin
         @(negedge clk);
         if (c == 1) begin
            // Operands are latched; these changes must have no effect.
            req_valid[sel] = 1'b0;
            src1[sel]      = ~a;
            src2[sel]      = ~b;
         end
         if (c <= 3) begin
            ea = (c == 3) ? a[31:16] : a[15:0];
            eb = (c == 2) ? b[31:16] : b[15:0];
            n_checks++;
            if (mul_a[sel] !== ea || mul_b[sel] !== eb || mul_en[sel] !== 1'b1 ||
                busy[sel] !== 1'b1 || req_ready[sel] !== 1'b0) begin
               n_fail++;
               $display("FAIL %s slot%0d: a=%h b=%h en=%b busy=%b rdy=%b, required a=%h b=%h en=1 busy=1 rdy=0",
                        nm, c - 1, mul_a[sel], mul_b[sel], mul_en[sel], busy[sel], req_ready[sel], ea, eb);
            end
         end
         if (rsp_valid[sel] === 1'b1) begin
            lat = c;
            n_checks++;
            if (rsp_result[sel] !== exp) begin
               n_fail++;
               $display("FAIL %s result: got %h required %h", nm, rsp_result[sel], exp);
            end
         end
      end
      n_checks++;
      if (lat != exp_lat) begin
         n_fail++;
         $display("FAIL %s latency: got %0d required %0d", nm, lat, exp_lat);
      end
      @(negedge clk);
      n_checks++;
      if (rsp_valid[sel] !== 1'b0 || req_ready[sel] !== 1'b1 || busy[sel] !== 1'b0) begin
         n_fail++;
         $display("FAIL %s after_rsp: vld=%b rdy=%b busy=%b required vld=0 rdy=1 busy=0",
                  nm, rsp_valid[sel], req_ready[sel], busy[sel]);
      end
   endtask

   task automatic test_stall();
      int w;
      @(negedge clk);
      rsp_ready[0] = 1'b0;
      req_valid[0] = 1'b1;
      src1[0]      = 32'h12345678;
      src2[0]      = 32'h9ABCDEF0;
      @(posedge clk);  // req_ready is 1 in IDLE, so this edge accepts
      @(negedge clk);
      req_valid[0] = 1'b0;
      w = 0;
      while (rsp_valid[0] !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      n_checks++;
      if (rsp_valid[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_rsp_timeout: rsp_valid=%b required 1", rsp_valid[0]);
         rsp_ready[0] = 1'b1;
         return;
      end
      for (int c = 0; c < 6; c++) begin
         req_valid[0] = 1'b1;  // competing request during the stall
         src1[0]      = 32'h00000002;
         src2[0]      = 32'h00000002;
         n_checks++;
         if (rsp_valid[0] !== 1'b1 || rsp_result[0] !== 32'h242D2080 || req_ready[0] !== 1'b0 ||
             mul_en[0] !== 1'b0 || state_dbg[0] !== 2'd3) begin
            n_fail++;
            $display("FAIL stall_cycle%0d: vld=%b res=%h rdy=%b en=%b st=%0d, required vld=1 res=242d2080 rdy=0 en=0 st=3",
                     c, rsp_valid[0], rsp_result[0], req_ready[0], mul_en[0], state_dbg[0]);
         end
         if (c < 5) @(negedge clk);
      end
      req_valid[0] = 1'b0;
      rsp_ready[0] = 1'b1;
      @(negedge clk);
      n_checks++;
      if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_release: vld=%b rdy=%b busy=%b required vld=0 rdy=1 busy=0",
                  rsp_valid[0], req_ready[0], busy[0]);
      end
   endtask

   task automatic test_reset_mid();
      int bad;
      @(negedge clk);
      rsp_ready[0] = 1'b1;
      req_valid[0] = 1'b1;
      src1[0]      = 32'h12345678;
      src2[0]      = 32'h9ABCDEF0;
      @(posedge clk);
      @(negedge clk);  // slot 0
      req_valid[0] = 1'b0;
      @(negedge clk);  // slot 1
      n_checks++;
      if (mul_a[0] !== 16'h5678 || mul_b[0] !== 16'h9ABC) begin
         n_fail++;
         $display("FAIL reset_mid_slot1: a=%h b=%h required 5678 9abc", mul_a[0], mul_b[0]);
      end
      reset[0] = 1'b1;
      #1;
      n_checks++;
      if (req_ready[0] !== 1'b0 || rsp_valid[0] !== 1'b0 || mul_en[0] !== 1'b0 ||
          busy[0] !== 1'b0 || rsp_result[0] !== 32'h0 || mul_a[0] !== 16'h0 || mul_b[0] !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_mid_values: rdy=%b vld=%b en=%b busy=%b res=%h a=%h b=%h, required all zero",
                  req_ready[0], rsp_valid[0], mul_en[0], busy[0], rsp_result[0], mul_a[0], mul_b[0]);
      end
      @(negedge clk);
      reset[0] = 1'b0;
      bad = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL reset_mid_no_rsp: %0d cycles with rsp_valid/busy high, required 0", bad);
      end
      do_op(0, 32'd7, 32'd9, 32'h0000003F, "after_reset_7x9");
   endtask

   // ---------------- sequence ----------------
   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      do_op(0, 32'd3,         32'd5,         32'h0000000F, "l1_3x5");
      do_op(0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001, "l1_ones");
      do_op(0, 32'h12345678,  32'h9ABCDEF0,  32'h242D2080, "l1_mixed");
      do_op(0, 32'h00010000,  32'h00010000,  32'h00000000, "l1_cross");
      test_stall();
      test_reset_mid();
      do_op(1, 32'd3,         32'd5,         32'h0000000F, "l3_3x5");
      do_op(1, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001, "l3_ones");
      do_op(1, 32'h12345678,  32'h9ABCDEF0,  32'h242D2080, "l3_mixed");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
